// File: rtl/radixr_digit_multiply_pipe_pkg.sv
// Shared sizing and digit-indexing helpers for the radix-r digit multiply pipe
// and the redundant adder tree that consumes its output digits.
package radixr_digit_multiply_pipe_pkg;

    localparam int DEFAULT_RADIX_BITS = 2;
    localparam int LOG2_RADIX         = DEFAULT_RADIX_BITS - 1;

    function automatic int out_digit_bits(input int rb);
        return rb + 1;
    endfunction

    function automatic int prod_bits(input int rb);
        return 2 * rb;
    endfunction

    function automatic int log2_radix(input int rb);
        return rb - 1;
    endfunction

    // Digit idx of width w occupies bits [digit_msb : digit_lsb]; digit 0 is least significant.
    function automatic int digit_lsb(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic int digit_msb(input int idx, input int w);
        return (idx + 1) * w - 1;
    endfunction

endpackage

// File: rtl/radixr_digit_recode.sv
// Carry-free recode of one digit product: x*y = t*r + w with w in [-r/2, r/2-1].
module radixr_digit_recode
    import radixr_digit_multiply_pipe_pkg::*;
#(
    parameter int radix_bits = 2
) (
    input  logic signed [radix_bits-1:0] x,
    input  logic signed [radix_bits-1:0] y,
    output logic signed [radix_bits:0]   t,
    output logic signed [radix_bits:0]   w
);

    localparam int PB   = prod_bits(radix_bits);
    localparam int OB   = out_digit_bits(radix_bits);
    localparam int L    = log2_radix(radix_bits);
    localparam int HALF = (L > 0) ? (1 << (L - 1)) : 0;

    // floor((v + r/2) / r) as an arithmetic shift
    function automatic logic signed [PB-1:0] round_quot(input logic signed [PB-1:0] v);
        return (v + PB'(HALF)) >>> L;
    endfunction

    logic signed [PB-1:0] p;
    logic signed [PB-1:0] tq;
    logic signed [PB-1:0] rem;

    assign p   = PB'(x) * PB'(y);
    assign tq  = round_quot(p);
    assign rem = p - (tq <<< L);
    assign t   = OB'(tq);
    assign w   = OB'(rem);

endmodule

// File: rtl/radixr_digit_multiply_pipe.sv
// Two-stage radix-r online digit-vector by digit multiplier with valid/ready on both sides.
// Optional build macro RADIXR_DIGIT_RANGE_CHECK_EN adds a registered range_err flag.
module radixr_digit_multiply_pipe
    import radixr_digit_multiply_pipe_pkg::*;
#(
    parameter int no_of_digits = 8,
    parameter int radix_bits   = 2,
    parameter int radix        = 2
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [no_of_digits*radix_bits-1:0]             din1,
    input  logic [radix_bits-1:0]                          din2,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [(no_of_digits+1)*(radix_bits+1)-1:0]     dout
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
    ,
    output logic                                           range_err
`endif
);

    localparam int OB = out_digit_bits(radix_bits);
    localparam int L  = log2_radix(radix_bits);
    localparam int DW = (no_of_digits + 1) * OB;

    if (radix != (1 << L)) begin : g_bad_radix
        $error("radix must equal 2**(radix_bits-1)");
    end

    logic signed [OB-1:0] t_c  [no_of_digits];
    logic signed [OB-1:0] w_c  [no_of_digits];
    logic signed [OB-1:0] t_p1 [no_of_digits];
    logic signed [OB-1:0] w_p1 [no_of_digits];
    logic                 vld_p1;
    logic                 vld_p2;
    logic                 s1_adv;
    logic                 s2_adv;
    logic [DW-1:0]        z_c;

    assign s2_adv    = !vld_p2 || out_ready;
    assign s1_adv    = !vld_p1 || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_p2;

    for (genvar i = 0; i < no_of_digits; i++) begin : g_rec
        radixr_digit_recode #(
            .radix_bits(radix_bits)
        ) u_rec (
            .x(din1[digit_msb(i, radix_bits):digit_lsb(i, radix_bits)]),
            .y(din2),
            .t(t_c[i]),
            .w(w_c[i])
        );
    end

    // ---- stage 1: per-digit transfer/residual registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && s1_adv) begin
            t_p1 <= t_c;
            w_p1 <= w_c;
        end
    end

    // Each digit absorbs the transfer from the digit below; the top transfer becomes the extra digit.
    always_comb begin
        z_c = '0;
        z_c[digit_lsb(0, OB) +: OB] = w_p1[0];
        for (int i = 1; i < no_of_digits; i++) begin
            z_c[digit_lsb(i, OB) +: OB] = w_p1[i] + t_p1[i-1];
        end
        z_c[digit_lsb(no_of_digits, OB) +: OB] = t_p1[no_of_digits-1];
    end

    // ---- stage 2: assembled product digits ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            dout   <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                dout <= z_c;
            end
        end
    end

`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
    localparam logic [radix_bits-1:0] NEG_R = radix_bits'(1) << L;

    logic [no_of_digits-1:0] bad_x;
    logic                    err_c;
    logic                    err_p1;

    always_comb begin
        bad_x = '0;
        for (int i = 0; i < no_of_digits; i++) begin
            bad_x[i] = (din1[digit_lsb(i, radix_bits) +: radix_bits] == NEG_R);
        end
    end

    assign err_c = (|bad_x) || (din2 == NEG_R);

    // ---- stage 1 / stage 2: illegal-digit flag follows its data ----
    always_ff @(posedge clk) begin
        if (in_valid && s1_adv) begin
            err_p1 <= err_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            range_err <= 1'b0;
        end else if (s2_adv && vld_p1) begin
            range_err <= err_p1;
        end
    end
`endif

endmodule

// File: tb/tb_radixr_digit_multiply_pipe.sv
// Self-checking bench: radix-4 x 4-digit and radix-2 x 8-digit instances vs. an arithmetic model.
module tb_radixr_digit_multiply_pipe;

    localparam int N4 = 4, RB4 = 3, R4 = 4, OB4 = 4, XW4 = N4*RB4, DW4 = (N4+1)*OB4;
    localparam int N2 = 8, RB2 = 2, R2 = 2, OB2 = 3, XW2 = N2*RB2, DW2 = (N2+1)*OB2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic iv4, ir4, ov4, or4;
    logic [XW4-1:0] d1_4;
    logic [RB4-1:0] d2_4;
    logic [DW4-1:0] dout4;
    logic iv2, ir2, ov2, or2;
    logic [XW2-1:0] d1_2;
    logic [RB2-1:0] d2_2;
    logic [DW2-1:0] dout2;
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
    logic re4, re2;
`endif

    int errors = 0;
    int checks = 0;
    logic [DW4-1:0] q4[$];

    radixr_digit_multiply_pipe #(.no_of_digits(N4), .radix_bits(RB4), .radix(R4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .din1(d1_4), .din2(d2_4),
        .out_valid(ov4), .out_ready(or4), .dout(dout4)
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
        , .range_err(re4)
`endif
    );

    radixr_digit_multiply_pipe #(.no_of_digits(N2), .radix_bits(RB2), .radix(R2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .din1(d1_2), .din2(d2_2),
        .out_valid(ov2), .out_ready(or2), .dout(dout2)
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
        , .range_err(re2)
`endif
    );

    // ---------------- reference model ----------------
    function automatic longint sx(input longint f, input int w);
        longint h = longint'(1) <<< (w - 1);
        return (f >= h) ? f - (h <<< 1) : f;
    endfunction

    function automatic longint fdiv(input longint a, input longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // Signed value of nd digits of width w in radix r.
    function automatic longint dval(input longint v, input int nd, input int w, input longint r);
        longint s = 0, sc = 1, m = (longint'(1) <<< w) - 1;
        for (int i = 0; i < nd; i++) begin
            s += sx((v >>> (i * w)) & m, w) * sc;
            sc *= r;
        end
        return s;
    endfunction

    function automatic longint model(input longint xv, input longint yv, input int n, input int rb);
        longint r = longint'(1) <<< (rb - 1);
        int ob = rb + 1;
        longint m = (longint'(1) <<< rb) - 1, om = (longint'(1) <<< ob) - 1;
        longint y = sx(yv & m, rb), x, p, t, w, tprev = 0, res = 0;
        for (int i = 0; i < n; i++) begin
            x = sx((xv >>> (i * rb)) & m, rb);
            p = x * y;
            t = fdiv(p + r / 2, r);
            w = p - t * r;
            res |= ((w + tprev) & om) << (i * ob);
            tprev = t;
        end
        res |= (tprev & om) << (n * ob);
        return res;
    endfunction

    task automatic rand4(output longint xs, output longint ys);
        xs = 0;
        for (int i = 0; i < N4; i++) xs |= (longint'(int'($urandom_range(6)) - 3) & 7) << (i * RB4);
        ys = longint'(int'($urandom_range(6)) - 3) & 7;
    endtask

    task automatic rand2(output longint xs, output longint ys);
        xs = 0;
        for (int i = 0; i < N2; i++) xs |= (longint'(int'($urandom_range(2)) - 1) & 3) << (i * RB2);
        ys = longint'(int'($urandom_range(2)) - 1) & 3;
    endtask

    function automatic logic ready4(input int mode, input int cyc);
        if (mode == 1) return ($urandom % 3) != 0;
        if (mode == 2) return cyc >= 4;
        return 1'b1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        iv4 = 0; or4 = 0; d1_4 = '0; d2_4 = '0;
        iv2 = 0; or2 = 0; d1_2 = '0; d2_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ov4 !== 1'b0) $display("FAIL reset_ov4: got %b expected 0", ov4);
        if (ov4 !== 1'b0) errors++;
        checks++; if (dout4 !== '0) begin errors++; $display("FAIL reset_dout4: got %h expected 0", dout4); end
        checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_ir4: got %b expected 1", ir4); end
        checks++; if (ov2 !== 1'b0 || dout2 !== '0) begin errors++; $display("FAIL reset_u2: ov %b dout %h expected 0/0", ov2, dout2); end
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
        checks++; if (re4 !== 1'b0) begin errors++; $display("FAIL reset_range_err: got %b expected 0", re4); end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One isolated transaction on the radix-4 instance: latency 2, one-cycle out_valid pulse.
    task automatic single4(input longint xv, input longint yv, input logic [DW4-1:0] exp,
                           input bit chk_data, input bit exp_err, input string name);
        string tag = exp_err ? "illegal" : "legal";
        d1_4 = XW4'(xv); d2_4 = RB4'(yv); iv4 = 1; or4 = 1;
        #1;
        checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b expected 1", name, ir4); end
        @(posedge clk); #1;
        iv4 = 0;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b expected 0", name, ov4); end
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid %b expected 1 (%s)", name, ov4, tag); end
        if (chk_data) begin
            checks++; if (dout4 !== exp) begin errors++; $display("FAIL %s_dout: got %h expected %h", name, dout4, exp); end
            checks++;
            if (dval(longint'(dout4), N4+1, OB4, R4) != sx(yv, RB4) * dval(xv, N4, RB4, R4)) begin
                errors++;
                $display("FAIL %s_value: got %0d expected %0d", name, dval(longint'(dout4), N4+1, OB4, R4),
                         sx(yv, RB4) * dval(xv, N4, RB4, R4));
            end
        end
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
        checks++; if (re4 !== exp_err) begin errors++; $display("FAIL %s_range_err: got %b expected %b", name, re4, exp_err); end
`endif
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL %s_pulse: out_valid %b expected 0", name, ov4); end
    endtask

    task automatic single2(input longint xv, input longint yv, input logic [DW2-1:0] exp, input string name);
        d1_2 = XW2'(xv); d2_2 = RB2'(yv); iv2 = 1; or2 = 1;
        @(posedge clk); #1;
        iv2 = 0;
        @(posedge clk); #1;
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL %s_latency: out_valid %b expected 1", name, ov2); end
        checks++; if (dout2 !== exp) begin errors++; $display("FAIL %s_dout: got %h expected %h", name, dout2, exp); end
        checks++;
        if (dval(longint'(dout2), N2+1, OB2, R2) != sx(yv, RB2) * dval(xv, N2, RB2, R2)) begin
            errors++;
            $display("FAIL %s_value: got %0d expected %0d", name, dval(longint'(dout2), N2+1, OB2, R2),
                     sx(yv, RB2) * dval(xv, N2, RB2, R2));
        end
`ifdef RADIXR_DIGIT_RANGE_CHECK_EN
        checks++; if (re2 !== 1'b0) begin errors++; $display("FAIL %s_range_err: got %b expected 0", name, re2); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_directed_radix4();
        // x digits all 3 (value 255), y = 3 / -3 / 0
        single4(longint'(12'b011_011_011_011), 3, {4'd2, 4'd3, 4'd3, 4'd3, 4'd1}, 1, 0, "r4_pos");
        single4(longint'(12'b011_011_011_011), 5, {4'hE, 4'hD, 4'hD, 4'hD, 4'hF}, 1, 0, "r4_neg");
        single4(longint'(12'b011_011_011_011), 0, '0, 1, 0, "r4_zero");
    endtask

    task automatic test_radix2();
        longint xs, ys;
        // digits 0..3 = 1,0,-1,1 ; y = -1 -> z = -1,0,-1,0,0.. (value -5)
        single2(longint'(16'b00_00_00_00_01_11_00_01), 3, 27'h00001C7, "r2_directed");
        for (int k = 0; k < 4; k++) begin
            rand2(xs, ys);
            single2(xs, ys, DW2'(model(xs, ys, N2, RB2)), "r2_random");
        end
    endtask

    task automatic test_illegal_digit();
        // -r digits: arithmetic as-is, must still complete; flag raised when enabled
        single4(longint'(12'b100_001_100_010), 4, '0, 0, 1, "r4_illegal");
        single4(longint'(12'b001_010_011_111), 2, DW4'(model(longint'(12'b001_010_011_111), 2, N4, RB4)),
                1, 0, "r4_legal_after");
    endtask

    // mode 0: out_ready high; mode 1: random out_ready; mode 2: out_ready low for 4 cycles
    task automatic stream4(input int n, input int mode, input string name);
        int sent = 0, got = 0, cyc = 0;
        logic [DW4-1:0] e, held;
        bit held_v = 0;
        longint xs, ys;
        q4.delete();
        held = '0;
        rand4(xs, ys);
        d1_4 = XW4'(xs); d2_4 = RB4'(ys); iv4 = 1; or4 = ready4(mode, cyc);
        while (got < n && cyc < 500) begin
            #1;
            if (held_v) begin
                checks++;
                if (ov4 !== 1'b1 || dout4 !== held) begin
                    errors++; $display("FAIL %s_stall_hold: got %b/%h expected 1/%h", name, ov4, dout4, held);
                end
            end
            if (mode == 2 && cyc == 3) begin
                checks++;
                if (sent != 2 || ir4 !== 1'b0) begin
                    errors++; $display("FAIL %s_full: accepted %0d in_ready %b expected 2/0", name, sent, ir4);
                end
            end
            held_v = ov4 && !or4;
            held   = dout4;
            if (ov4 && or4) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++; $display("FAIL %s_spurious: got %h expected no output", name, dout4);
                end else begin
                    e = q4.pop_front();
                    if (dout4 !== e) begin errors++; $display("FAIL %s_dout: got %h expected %h", name, dout4, e); end
                end
                got++;
            end
            if (iv4 && ir4) begin
                q4.push_back(DW4'(model(xs, ys, N4, RB4)));
                sent++;
                rand4(xs, ys);
            end
            @(posedge clk); #1;
            cyc++;
            iv4 = (sent < n); d1_4 = XW4'(xs); d2_4 = RB4'(ys); or4 = ready4(mode, cyc);
        end
        checks++; if (got != n) begin errors++; $display("FAIL %s_timeout: got %0d results expected %0d", name, got, n); end
        if (mode == 0) begin
            checks++; if (cyc != n + 2) begin errors++; $display("FAIL %s_throughput: got %0d cycles expected %0d", name, cyc, n + 2); end
        end
        iv4 = 0; or4 = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        longint xs, ys;
        rand4(xs, ys);
        d1_4 = XW4'(xs); d2_4 = RB4'(ys); iv4 = 1; or4 = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ir4 !== 1'b0 || ov4 !== 1'b1) begin errors++; $display("FAIL midrst_full: in_ready %b out_valid %b expected 0/1", ir4, ov4); end
        iv4 = 0; rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL midrst_ov: got %b expected 0", ov4); end
        checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL midrst_ir: got %b expected 1", ir4); end
        rst_n = 1'b1; or4 = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL midrst_stale: cycle %0d out_valid %b expected 0", k, ov4); end
        end
    endtask

    initial begin
        test_reset();
        test_directed_radix4();
        test_radix2();
        test_illegal_digit();
        stream4(20, 0, "b2b");
        stream4(40, 1, "rand_ready");
        stream4(5, 2, "backpressure");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
